rr_mux_arb: RTL and testbench
=============================

Name: rr_mux_arb

Overview:
Parametrised successor to the combinational one-hot-select 16-to-1 mux in the four-bit ALU datapath. Selects one of NUM_CH DATA_W-bit input channels and presents it on a single registered output. Uses valid/ready handshakes on every channel and on the output. Supports two selection modes: fixed (external select, as the old mux) and round-robin arbitration. Sits between ALU operand/result sources and the shared ALU input or writeback bus.

Parameters:
- NUM_CH, 16, number of input channels (2..64).
- DATA_W, 4, width of each channel's data.
- SEL_W, $clog2(NUM_CH), select/grant index width (derived; do not override).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_data  in  NUM_CH*DATA_W  channel i occupies bits [i*DATA_W +: DATA_W].
- in_valid  in  NUM_CH  channel i has data.
- in_ready  out  NUM_CH  channel i data accepted this cycle (one-hot or zero).
- mode  in  1  0 = fixed select, 1 = round-robin.
- fixed_sel  in  SEL_W  channel index used in fixed mode.
- out_data  out  DATA_W  registered selected data.
- out_sel  out  SEL_W  index of the channel that supplied out_data.
- out_valid  out  1  out_data/out_sel valid.
- out_ready  in  1  downstream accepts.

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_data=0, out_sel=0, rr_ptr=NUM_CH-1, so the first RR search starts at channel 0.
- load = !out_valid || out_ready.
- Output register holds out_data/out_sel stable while out_valid && !out_ready.
- Fixed mode: candidate = fixed_sel. If fixed_sel >= NUM_CH, no grant is made.
- RR mode: candidate = first i with in_valid[i], searching rr_ptr+1, rr_ptr+2, ... modulo NUM_CH (wrap-around).
- Grant: when load && in_valid[candidate]:
  - in_ready[candidate]=1 (combinational, same cycle).
  - Next edge: out_data<=in_data[candidate], out_sel<=candidate, out_valid<=1.
  - RR mode only: rr_ptr<=candidate.
- No grant while load: next edge out_valid<=0. in_ready=0 whenever load=0.
- Latency: 1 cycle input accept to out_valid. Full throughput of 1 transfer/cycle with out_ready held high.
- rr_ptr is unchanged by fixed-mode grants and by cycles without a grant.
- Mode or fixed_sel change takes effect in the same cycle's arbitration. Data already held in the output register is unaffected.
- Single valid channel in RR mode: it is granted every cycle.
- All channels valid in RR mode: grants cycle 0,1,...,NUM_CH-1,0,...
- Reset mid-transfer: held data is dropped, out_valid=0 immediately. No in_ready is asserted while rst_n=0.

Optional Feature:
- Macro RR_MUX_GRANT_CNT_EN.
- Defined: adds output port grant_cnt (out, 16). The counter increments on every output handshake (out_valid && out_ready), saturates at 16'hFFFF, and resets to 0.
- Undefined: port and counter are absent. All other behaviour is identical.

Decomposition:
- Package rr_mux_pkg:
  - mode constants MODE_FIXED=1'b0, MODE_RR=1'b1;
  - GRANT_CNT_W=16.
- Sub-module rr_picker: combinational rotating-priority picker.
  - Inputs: req[NUM_CH], base[SEL_W].
  - Outputs: gnt_idx[SEL_W], gnt_vld.
  - Instantiated once in rr_mux_arb.

Test Plan:
- Fixed mode, one-hot walk: for i=0..15, in_valid=16'hFFFF, in_data channel i = i[3:0], fixed_sel=i, out_ready=1 -> one cycle later out_data=i, out_sel=i, out_valid=1, in_ready=(1<<i).
- RR fairness: mode=1, all 16 valid, out_ready=1 for 20 cycles -> out_sel sequence 0,1,...,15,0,1,2,3.
- RR skip/wrap: valid only on channels 3 and 14, rr_ptr after reset -> grants 3,14,3,14. Then drop channel 3 -> 14,14.
- Backpressure: out_ready=0 for 3 cycles after out_valid -> out_data/out_sel stable, in_ready=0. Release -> next grant next cycle with no lost or duplicated transfer.
- fixed_sel=15 with NUM_CH=12 build -> out_valid stays 0, in_ready all 0.
- Async reset asserted mid-stream while out_valid=1 -> out_valid=0 immediately. After release, first RR grant goes to the lowest valid channel. With RR_MUX_GRANT_CNT_EN, grant_cnt returns to 0.

Source files
------------

// File: rtl/rr_mux_pkg.sv
// Shared constants for the round-robin / fixed-select output mux.
package rr_mux_pkg;
  localparam logic MODE_FIXED  = 1'b0;
  localparam logic MODE_RR     = 1'b1;
  localparam int   GRANT_CNT_W = 16;
endpackage

// File: rtl/rr_picker.sv
// Rotating-priority picker: returns the first requester after base, wrapping modulo NUM_CH.
module rr_picker #(
  parameter int NUM_CH = 16,
  parameter int SEL_W  = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [SEL_W-1:0]  base,
  output logic [SEL_W-1:0]  gnt_idx,
  output logic              gnt_vld
);

  always_comb begin
    int             idx;
    logic [SEL_W-1:0] idx_s;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    idx     = 0;
    idx_s   = '0;
    // base itself is searched last, so a lone requester at base still wins
    for (int k = 1; k <= NUM_CH; k++) begin
      idx = int'(base) + k;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      idx_s = SEL_W'(idx);
      if (!gnt_vld && req[idx_s]) begin
        gnt_vld = 1'b1;
        gnt_idx = idx_s;
      end
    end
  end

endmodule

// File: rtl/rr_mux_arb.sv
// NUM_CH-to-1 valid/ready mux with fixed-select or round-robin arbitration and a registered output.
// Optional saturating output-handshake counter enabled by macro RR_MUX_GRANT_CNT_EN.
module rr_mux_arb
  import rr_mux_pkg::*;
#(
  parameter int NUM_CH = 16,
  parameter int DATA_W = 4,
  parameter int SEL_W  = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic [NUM_CH-1:0]        in_valid,
  output logic [NUM_CH-1:0]        in_ready,
  input  logic                     mode,
  input  logic [SEL_W-1:0]         fixed_sel,
  output logic [DATA_W-1:0]        out_data,
  output logic [SEL_W-1:0]         out_sel,
  output logic                     out_valid,
`ifdef RR_MUX_GRANT_CNT_EN
  output logic [GRANT_CNT_W-1:0]   grant_cnt,
`endif
  input  logic                     out_ready
);

  logic [DATA_W-1:0] chan_data [NUM_CH];
  logic [DATA_W-1:0] out_data_reg;
  logic [SEL_W-1:0]  out_sel_reg;
  logic              out_valid_reg;
  logic [SEL_W-1:0]  rr_ptr_reg;

  logic [SEL_W-1:0]  pick_idx;
  logic              pick_vld;
  logic [SEL_W-1:0]  cand_idx;
  logic              cand_vld;
  logic              fixed_ok;
  logic              load;
  logic              grant;

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_unpack
      assign chan_data[gi] = in_data[gi*DATA_W +: DATA_W];
    end
  endgenerate

  rr_picker #(.NUM_CH(NUM_CH), .SEL_W(SEL_W)) u_picker (
    .req     (in_valid),
    .base    (rr_ptr_reg),
    .gnt_idx (pick_idx),
    .gnt_vld (pick_vld)
  );

  // Non-power-of-two builds can be handed a select beyond the last channel
  assign fixed_ok = int'(fixed_sel) < NUM_CH;

  always_comb begin
    cand_idx = fixed_sel;
    cand_vld = fixed_ok && in_valid[fixed_sel];
    if (mode == MODE_RR) begin
      cand_idx = pick_idx;
      cand_vld = pick_vld;
    end
  end

  assign load     = !out_valid_reg || out_ready;
  assign grant    = rst_n && load && cand_vld;
  assign in_ready = grant ? (NUM_CH'(1) << cand_idx) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_sel_reg   <= '0;
      rr_ptr_reg    <= SEL_W'(NUM_CH - 1);
    end else if (load) begin
      out_valid_reg <= grant;
      if (grant) begin
        out_data_reg <= chan_data[cand_idx];
        out_sel_reg  <= cand_idx;
        if (mode == MODE_RR) rr_ptr_reg <= cand_idx;
      end
    end
  end

  assign out_data  = out_data_reg;
  assign out_sel   = out_sel_reg;
  assign out_valid = out_valid_reg;

`ifdef RR_MUX_GRANT_CNT_EN
  logic [GRANT_CNT_W-1:0] grant_cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt_reg <= '0;
    end else if (out_valid_reg && out_ready && grant_cnt_reg != '1) begin
      grant_cnt_reg <= grant_cnt_reg + GRANT_CNT_W'(1);
    end
  end

  assign grant_cnt = grant_cnt_reg;
`endif

endmodule

// File: tb/tb_rr_mux_arb.sv
// Self-checking bench for rr_mux_arb: per-cycle behavioural model plus directed literal checks.
module tb_rr_mux_arb;

  logic        clk;
  logic        rst_n;
  logic [63:0] in_data;
  logic [15:0] in_valid;
  logic [15:0] in_ready;
  logic        mode;
  logic [3:0]  fixed_sel;
  logic [3:0]  out_data;
  logic [3:0]  out_sel;
  logic        out_valid;
  logic        out_ready;

  logic [47:0] in_data12;
  logic [11:0] in_valid12;
  logic [11:0] in_ready12;
  logic        mode12;
  logic [3:0]  fixed_sel12;
  logic [3:0]  out_data12;
  logic [3:0]  out_sel12;
  logic        out_valid12;
  logic        out_ready12;

`ifdef RR_MUX_GRANT_CNT_EN
  logic [15:0] grant_cnt;
  logic [15:0] grant_cnt12;
`endif

  int tests  = 0;
  int errors = 0;

  rr_mux_arb #(.NUM_CH(16), .DATA_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .fixed_sel(fixed_sel), .out_data(out_data), .out_sel(out_sel),
    .out_valid(out_valid),
`ifdef RR_MUX_GRANT_CNT_EN
    .grant_cnt(grant_cnt),
`endif
    .out_ready(out_ready)
  );

  rr_mux_arb #(.NUM_CH(12), .DATA_W(4)) dut12 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data12), .in_valid(in_valid12), .in_ready(in_ready12),
    .mode(mode12), .fixed_sel(fixed_sel12), .out_data(out_data12), .out_sel(out_sel12),
    .out_valid(out_valid12),
`ifdef RR_MUX_GRANT_CNT_EN
    .grant_cnt(grant_cnt12),
`endif
    .out_ready(out_ready12)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Behavioural model of the 16-channel instance, advanced once per cycle at the falling edge
  bit          m_valid;
  int          m_data;
  int          m_sel;
  int          m_ptr;
  int          m_cnt;

  always @(negedge clk) begin
    bit          ld;
    bit          ok;
    int          c;
    logic [15:0] exp_rdy;
    if (!rst_n) begin
      chk("model_rst_valid", out_valid, 0);
      chk("model_rst_ready", in_ready, 0);
      m_valid = 0; m_data = 0; m_sel = 0; m_ptr = 15; m_cnt = 0;
    end else begin
      chk("model_out_valid", out_valid, m_valid);
      if (m_valid) begin
        chk("model_out_data", out_data, m_data);
        chk("model_out_sel", out_sel, m_sel);
      end
`ifdef RR_MUX_GRANT_CNT_EN
      chk("model_grant_cnt", grant_cnt, m_cnt);
      if (m_valid && out_ready && m_cnt < 65535) m_cnt = m_cnt + 1;
`endif
      ld = !m_valid || out_ready;
      ok = 0;
      c  = 0;
      if (mode) begin
        for (int k = 1; k <= 16; k++) begin
          if (!ok && in_valid[(m_ptr + k) % 16]) begin
            ok = 1;
            c  = (m_ptr + k) % 16;
          end
        end
      end else begin
        c  = int'(fixed_sel);
        ok = in_valid[c];
      end
      exp_rdy = (ld && ok) ? (16'd1 << c) : 16'd0;
      chk("model_in_ready", in_ready, exp_rdy);
      if (ld) begin
        m_valid = ok;
        if (ok) begin
          m_data = int'(in_data[c*4 +: 4]);
          m_sel  = c;
          if (mode) m_ptr = c;
        end
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  int got [20];
  int exp_skip [6] = '{3, 14, 3, 14, 14, 14};
  int held_sel;
  int held_data;

  initial begin
    rst_n = 1'b0;
    in_valid = '0; mode = 1'b0; fixed_sel = '0; out_ready = 1'b1;
    in_valid12 = '0; mode12 = 1'b0; fixed_sel12 = '0; out_ready12 = 1'b1;
    for (int j = 0; j < 16; j++) in_data[j*4 +: 4] = 4'(j);
    for (int j = 0; j < 12; j++) in_data12[j*4 +: 4] = 4'(j);
    step();
    step();
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_data", out_data, 0);
    chk("reset_out_sel", out_sel, 0);
`ifdef RR_MUX_GRANT_CNT_EN
    chk("reset_grant_cnt", grant_cnt, 0);
`endif
    rst_n = 1'b1;

    // Fixed mode one-hot walk
    in_valid = 16'hFFFF;
    mode = 1'b0;
    for (int i = 0; i < 16; i++) begin
      fixed_sel = 4'(i);
      #1;
      chk("fixed_in_ready", in_ready, 16'd1 << i);
      step();
      chk("fixed_out_data", out_data, i);
      chk("fixed_out_sel", out_sel, i);
      chk("fixed_out_valid", out_valid, 1);
    end

    // Round-robin fairness, all channels requesting
    do_reset();
    mode = 1'b1;
    in_valid = 16'hFFFF;
    for (int i = 0; i < 20; i++) begin
      step();
      got[i] = int'(out_sel);
    end
    for (int i = 0; i < 20; i++) chk("rr_fair_seq", got[i], i % 16);

    // Round-robin skip and wrap
    do_reset();
    in_valid = 16'h4008;
    for (int i = 0; i < 4; i++) begin
      step();
      got[i] = int'(out_sel);
    end
    in_valid = 16'h4000;
    for (int i = 4; i < 6; i++) begin
      step();
      got[i] = int'(out_sel);
    end
    for (int i = 0; i < 6; i++) chk("rr_skip_seq", got[i], exp_skip[i]);

    // Backpressure: output must hold, inputs must not be accepted
    do_reset();
    in_valid = 16'hFFFF;
    step();
    chk("bp_first_sel", out_sel, 0);
    held_sel  = int'(out_sel);
    held_data = int'(out_data);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_in_ready", in_ready, 0);
      step();
      chk("bp_hold_sel", out_sel, held_sel);
      chk("bp_hold_data", out_data, held_data);
      chk("bp_hold_valid", out_valid, 1);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", in_ready, 16'h0002);
    step();
    chk("bp_next_sel", out_sel, 1);
    chk("bp_next_data", out_data, 1);

    // 12-channel build: out-of-range select never grants, last channel does
    in_valid12 = 12'hFFF;
    fixed_sel12 = 4'd15;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("nc12_oob_ready", in_ready12, 0);
      step();
      chk("nc12_oob_valid", out_valid12, 0);
    end
    fixed_sel12 = 4'd12;
    #1;
    chk("nc12_12_ready", in_ready12, 0);
    fixed_sel12 = 4'd11;
    #1;
    chk("nc12_11_ready", in_ready12, 12'h800);
    step();
    chk("nc12_11_sel", out_sel12, 11);
    chk("nc12_11_valid", out_valid12, 1);

    // Asynchronous reset in the middle of a stream
    in_valid = 16'hFFFF;
    step();
    step();
    chk("arst_pre_valid", out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_in_ready", in_ready, 0);
`ifdef RR_MUX_GRANT_CNT_EN
    chk("arst_grant_cnt", grant_cnt, 0);
`endif
    step();
    step();
    in_valid = 16'h0220;
    rst_n = 1'b1;
    step();
    chk("arst_first_sel", out_sel, 5);
    chk("arst_first_valid", out_valid, 1);
    step();
    chk("arst_second_sel", out_sel, 9);
    step();

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
